uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// parity codes and the parity sanitiser.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Code 3 is undefined for the transmitter, so it is folded onto "no parity".
  function automatic logic [1:0] sanitize_parity(input logic [1:0] code);
    return (code == PAR_ODD || code == PAR_EVEN) ? code : PAR_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first valid index at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_valid
);

  localparam int IW = $clog2(N);

  // Scan from the farthest offset back to ptr so the nearest valid wins last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = |valid;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (valid[idx]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources.
// Frame: IDLE -> GRANT -> SEND -> WAIT_DONE -> GAP -> IDLE.
// req_ready is presented the cycle after GRANT and tx_send the cycle after
// SEND, so with a request first seen in cycle 0 req_ready shows in cycle 2
// and tx_send in cycle 3.
// Optional macro UART_ARB_TIMEOUT_EN: bounds WAIT_DONE to TIMEOUT_CLKS cycles
// and raises the sticky timeout_err when the bound is hit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int GAP_CLKS     = 16,
  parameter int TIMEOUT_CLKS = 8192,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [1:0]                   parity_type,
  output logic                         tx_send,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic [1:0]                   tx_parity_type,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         timeout_err
);

  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_t            state, next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [GAP_W-1:0]  gap_cnt;
  logic              timeout_hit;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; tx_done is only looked at in WAIT_DONE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (any_valid) next_state = S_GRANT;
      S_GRANT:     next_state = S_SEND;
      S_SEND:      next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done || timeout_hit) next_state = S_GAP;
      S_GAP:       if (gap_cnt == GAP_LAST) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Registered outputs, round-robin pointer and guard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr         <= '0;
      req_ready      <= '0;
      tx_send        <= 1'b0;
      tx_data        <= '0;
      tx_parity_type <= PAR_NONE;
      busy           <= 1'b0;
      grant_id       <= '0;
      gap_cnt        <= '0;
    end else begin
      req_ready <= '0;
      tx_send   <= 1'b0;
      busy      <= (next_state != S_IDLE);
      gap_cnt   <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state == S_IDLE && any_valid) begin
        grant_id       <= winner;
        tx_parity_type <= sanitize_parity(parity_type);
      end

      if (state == S_GRANT) begin
        req_ready <= NUM_REQ'(1) << grant_id;
        tx_data   <= req_data[grant_id*DATA_BITS +: DATA_BITS];
        rr_ptr    <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
      end

      if (state == S_SEND) tx_send <= 1'b1;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic [TO_W-1:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT_DONE) && (wait_cnt == TO_LAST);

  // WAIT_DONE watchdog; a tx_done landing on the last cycle is not an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT_DONE) ? wait_cnt + TO_W'(1) : '0;
      if (timeout_hit && !tx_done) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. A single driver process plays the requesters
// and the transmitter; a monitor process pops the expected-frame queue on
// every req_ready / tx_send. The timeout scenario runs only when
// UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DB  = 8;
  localparam int GAP = 16;
  localparam int TO  = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DB-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [1:0]        parity_type = 2'd0;
  logic              tx_send;
  logic [DB-1:0]     tx_data;
  logic [1:0]        tx_parity_type;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;
  logic              timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_BITS(DB), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .parity_type(parity_type), .tx_send(tx_send),
    .tx_data(tx_data), .tx_parity_type(tx_parity_type), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [1:0] par;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int sends = 0;
  int done_cnt = 0;
  int done_delay = 5;
  bit ready_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: requesters drop valid on their ready, transmitter answers
  // tx_send with a one-cycle tx_done done_delay cycles later (0 = never).
  task automatic step();
    @(negedge clk);
    cyc++;
    tx_done = 1'b0;
    for (int i = 0; i < NR; i++) if (req_ready[i]) req_valid[i] = 1'b0;
    if (tx_send) begin
      sends++;
      done_cnt = done_delay;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
  endtask

  task automatic request(input int id, input logic [7:0] d);
    req_data[id*DB +: DB] = d;
    req_valid[id] = 1'b1;
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input logic [1:0] p);
    frame_t f;
    f.id = id; f.data = d; f.par = p;
    exp_q.push_back(f);
  endtask

  task automatic wait_sends(input int n);
    int target;
    int k;
    target = sends + n;
    k = 0;
    while (sends < target && k < 80 * n) begin step(); k++; end
    check("sends_within_budget", 32'(sends >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin step(); k++; end
    check("returned_to_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: every req_ready / tx_send must match the head of the queue.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_ready: got req_ready=%b, expected no acceptance", req_ready);
          end else begin
            check("req_ready_onehot", 32'(req_ready), 32'(1) << exp_q[0].id);
            ready_seen = 1'b1;
          end
        end
        if (tx_send) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_send: got tx_send=1 tx_data=0x%0h, expected no frame", tx_data);
          end else begin
            f = exp_q.pop_front();
            check("ready_before_send", 32'(ready_seen), 32'd1);
            ready_seen = 1'b0;
            check("tx_data", 32'(tx_data), 32'(f.data));
            check("tx_parity_type", 32'(tx_parity_type), 32'(f.par));
            check("grant_id", 32'(grant_id), 32'(f.id));
          end
        end
      end
    end
  end

  initial begin
    int td;
    int k;
    int gap_sends;
    int s_cyc;

    // Reset values while rst is held.
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_parity", 32'(tx_parity_type), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Single request: ready in cycle 2, send in cycle 3.
    parity_type = 2'd2;
    request(0, 8'h55);
    expect_frame(0, 8'h55, 2'd2);
    step();
    check("busy_cycle1", 32'(busy), 32'd1);
    check("ready_not_cycle1", 32'(req_ready), 32'd0);
    step();
    check("ready_cycle2", 32'(req_ready), 32'b0001);
    check("send_not_cycle2", 32'(tx_send), 32'd0);
    step();
    check("send_cycle3", 32'(tx_send), 32'd1);

    // tx_done 5 cycles after tx_send, then a 16-cycle guard; a request
    // raised during GAP must wait for IDLE.
    k = 0;
    while (!tx_done && k < 20) begin step(); k++; end
    td = cyc;
    step();
    request(1, 8'h66);
    expect_frame(1, 8'h66, 2'd2);
    gap_sends = 0;
    k = 0;
    while (busy && k < 40) begin
      step();
      if (tx_send) gap_sends++;
      k++;
    end
    check("busy_low_after_gap", 32'(cyc - td), 32'(GAP + 1));
    check("no_send_in_gap", 32'(gap_sends), 32'd0);
    wait_sends(1);
    wait_idle();

    // Stray tx_done in IDLE does nothing.
    tx_done = 1'b1;
    step();
    step();
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_grant", 32'(grant_id), 32'd1);

    // Parity code 3 sanitised; a later parity change does not affect the frame.
    parity_type = 2'd3;
    request(2, 8'h3C);
    expect_frame(2, 8'h3C, 2'd0);
    step();
    parity_type = 2'd1;
    wait_sends(1);
    wait_idle();

    // Reset while waiting for tx_done; arbitration restarts at requester 0.
    request(1, 8'h11);
    expect_frame(1, 8'h11, 2'd1);
    done_delay = 0;
    wait_sends(1);
    step(); step();
    check("busy_in_wait_done", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_tx_parity", 32'(tx_parity_type), 32'd0);
    check("abort_grant_id", 32'(grant_id), 32'd0);
    check("abort_ready_send", 32'({req_ready, tx_send}), 32'd0);
    step(); step();
    rst = 1'b0;
    done_delay = 3;
    done_cnt = 0;
    parity_type = 2'd2;
    request(1, 8'h71);
    request(3, 8'h73);
    expect_frame(1, 8'h71, 2'd2);
    expect_frame(3, 8'h73, 2'd2);
    wait_sends(2);
    wait_idle();

    // All four valid from rr_ptr 0; requester 0 re-requests after its turn.
    parity_type = 2'd1;
    for (int i = 0; i < NR; i++) begin
      request(i, 8'hA0 + 8'(i));
      expect_frame(i, 8'hA0 + 8'(i), 2'd1);
    end
    wait_sends(1);
    request(0, 8'hA4);
    expect_frame(0, 8'hA4, 2'd1);
    wait_sends(4);
    wait_idle();

`ifdef UART_ARB_TIMEOUT_EN
    // tx_done withheld: timeout after TO cycles of WAIT_DONE, then service resumes.
    done_delay = 0;
    request(2, 8'hE2);
    expect_frame(2, 8'hE2, 2'd1);
    wait_sends(1);
    s_cyc = cyc;
    k = 0;
    while (!timeout_err && k < 2 * TO) begin step(); k++; end
    check("timeout_cycle", 32'(cyc - s_cyc), 32'(TO));
    done_delay = 3;
    request(3, 8'hE3);
    expect_frame(3, 8'hE3, 2'd1);
    wait_sends(1);
    wait_idle();
    check("timeout_sticky", 32'(timeout_err), 32'd1);
`else
    s_cyc = 0;
    check("timeout_tied_low", 32'(timeout_err), 32'd0);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
